// File: rtl/cim_psum_acc_pkg.sv
// Shared constants for the CIM partial-sum accumulator.
//   LANES_DEF / IN_W_DEF / ACC_W_DEF : default lane count and widths
//   state_t                          : controller state encoding
package cim_psum_acc_pkg;

    localparam int unsigned LANES_DEF = 8;
    localparam int unsigned IN_W_DEF  = 8;
    localparam int unsigned ACC_W_DEF = IN_W_DEF + 10;

    localparam int unsigned LEN_W = 10;
    localparam int unsigned GRP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cim_acc_lane.sv
// One accumulator lane.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear the running accumulator
//   i_add      : add i_psum (zero-extended) into the accumulator
//   i_load     : with i_add, last beat: publish sum to o_sum and restart at 0
//   i_psum     : unsigned partial sum for this lane
//   o_sum      : registered group result
module cim_acc_lane #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic             i_load,
    input  logic [IN_W-1:0]  i_psum,
    output logic [ACC_W-1:0] o_sum
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_sum;

    // Wraps modulo 2^ACC_W; no saturation.
    assign w_sum = r_acc + ACC_W'(i_psum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sum <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            if (i_load) begin
                r_acc <= '0;
                r_sum <= w_sum;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/cim_psum_acc.sv
// Multi-lane partial-sum accumulator for a CIM macro.
//   clk, rst_n           : clock, async active-low reset
//   start                : command pulse (IDLE only)
//   acc_len, num_grp     : beats per group - 1, groups per command - 1
//   in_valid/in_ready    : partial-sum beat handshake, in_psum packed per lane
//   out_valid/out_ready  : group result handshake, out_sum packed per lane
//   busy                 : not IDLE
//   done                 : one-cycle pulse after the final result is taken
module cim_psum_acc
    import cim_psum_acc_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       acc_len,
    input  logic [GRP_W-1:0]       num_grp,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_psum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_sum,
    output logic                   busy,
    output logic                   done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_acc_len;
    logic [GRP_W-1:0] r_num_grp;
    logic [LEN_W-1:0] r_beat;
    logic [GRP_W-1:0] r_grp;
    logic             r_out_valid;
    logic             r_done;

    logic w_clr;
    logic w_last_beat;
    logic w_add;
    logic w_load;
    logic w_final;
    logic w_out_hs;

    assign w_clr       = (r_state == ST_IDLE) && start;
    assign w_last_beat = (r_beat == r_acc_len);
    // The last beat may only stall while the previous result is still unread.
    assign in_ready    = (r_state == ST_ACCUM) &&
                         !(w_last_beat && r_out_valid && !out_ready);
    assign w_add       = in_valid && in_ready;
    assign w_load      = w_add && w_last_beat;
    assign w_final     = w_load && (r_grp == r_num_grp);
    assign w_out_hs    = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)    w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_final)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_hs) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc_len   <= '0;
            r_num_grp   <= '0;
            r_beat      <= '0;
            r_grp       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_DRAIN) && w_out_hs;

            if (w_clr) begin
                r_acc_len <= acc_len;
                r_num_grp <= num_grp;
                r_beat    <= '0;
                r_grp     <= '0;
            end else if (w_add) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    r_grp  <= r_grp + GRP_W'(1);
                end else begin
                    r_beat <= r_beat + LEN_W'(1);
                end
            end

            // A new result loading on the handshake edge keeps valid high.
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cim_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (w_clr),
            .i_add  (w_add),
            .i_load (w_load),
            .i_psum (in_psum[k*IN_W +: IN_W]),
            .o_sum  (out_sum[k*ACC_W +: ACC_W])
        );
    end

    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_cim_psum_acc.sv
// Directed self-checking bench for cim_psum_acc.
module tb_cim_psum_acc;

    localparam int LANES = 8;
    localparam int IN_W  = 8;
    localparam int ACC_W = 18;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [9:0]             acc_len;
    logic [7:0]             num_grp;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_psum;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] out_sum;
    logic                   busy;
    logic                   done;

    int n_total;
    int n_bad;

    cim_psum_acc #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_len   (acc_len),
        .num_grp   (num_grp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // lane k = base + step*k
    function automatic logic [LANES*IN_W-1:0] pk(input int base, input int step);
        logic [LANES*IN_W-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[k*IN_W +: IN_W] = IN_W'(base + step*k);
        return v;
    endfunction

    task automatic chk_lanes(input string tag, input int base, input int step);
        for (int k = 0; k < LANES; k++)
            chk(tag, 64'(out_sum[k*ACC_W +: ACC_W]), 64'(base + step*k));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int grp);
        start   = 1'b1;
        acc_len = 10'(len);
        num_grp = 8'(grp);
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
    endtask

    // Presents one beat and returns #1 after the accepting edge, in_valid left high.
    task automatic send_beat(input logic [LANES*IN_W-1:0] v);
        int n;
        in_valid = 1'b1;
        in_psum  = v;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("beat_timeout", 64'(in_ready), 64'd1);
        tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_idle", 64'(busy), 64'd0);
        tick();
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        logic seen_done;
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        acc_len   = '0;
        num_grp   = '0;
        in_valid  = 1'b0;
        in_psum   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_sum_zero", 64'(out_sum == '0), 64'd1);

        // 4 beats of 0xFF -> 1020 per lane
        out_ready = 1'b1;
        do_start(3, 0);
        for (int i = 0; i < 3; i++) begin
            send_beat(pk(255, 0));
            chk("s1_no_early_valid", 64'(out_valid), 64'd0);
        end
        send_beat(pk(255, 0));
        in_valid = 1'b0;
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk_lanes("s1_sum", 1020, 0);
        chk("s1_drain_busy", 64'(busy), 64'd1);
        chk("s1_drain_ready", 64'(in_ready), 64'd0);
        tick();
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_idle", 64'(busy), 64'd0);
        chk("s1_valid_clr", 64'(out_valid), 64'd0);
        tick();
        chk("s1_done_once", 64'(done), 64'd0);

        // 1024 beats, lane k = k+1 -> 1024*(k+1)
        do_start(1023, 0);
        for (int i = 0; i < 1024; i++) send_beat(pk(1, 1));
        in_valid = 1'b0;
        chk("s2_valid", 64'(out_valid), 64'd1);
        chk_lanes("s2_sum", 1024, 1024);
        wait_done();

        // backpressure: acc_len=1, three groups, out_ready low
        out_ready = 1'b0;
        do_start(1, 2);
        send_beat(pk(1, 0));
        send_beat(pk(2, 0));
        chk("s3_g0_valid", 64'(out_valid), 64'd1);
        chk_lanes("s3_g0_sum", 3, 0);
        in_psum = pk(10, 0);
        tick();
        in_psum = pk(20, 0);
        chk("s3_stall", 64'(in_ready), 64'd0);
        repeat (3) tick();
        chk("s3_stall_hold", 64'(in_ready), 64'd0);
        chk_lanes("s3_g0_hold", 3, 0);
        out_ready = 1'b1;
        #1;
        chk("s3_release", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b0;
        chk("s3_g1_valid", 64'(out_valid), 64'd1);
        chk_lanes("s3_g1_sum", 30, 0);
        in_psum = pk(100, 0);
        tick();
        in_psum = pk(50, 0);
        chk("s3_stall2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s3_g2_valid", 64'(out_valid), 64'd1);
        chk_lanes("s3_g2_sum", 150, 0);
        chk("s3_drain_ready", 64'(in_ready), 64'd0);
        chk("s3_drain_busy", 64'(busy), 64'd1);
        tick();
        chk("s3_done", 64'(done), 64'd1);
        tick();

        // acc_len=0, four groups back to back
        out_ready = 1'b1;
        do_start(0, 3);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_psum  = pk(20 + 10*i, 2);
            chk("s4_ready", 64'(in_ready), 64'd1);
            tick();
            chk("s4_valid", 64'(out_valid), 64'd1);
            chk_lanes("s4_sum", 20 + 10*i, 2);
        end
        in_valid = 1'b0;
        chk("s4_drain_ready", 64'(in_ready), 64'd0);
        tick();
        chk("s4_done", 64'(done), 64'd1);
        tick();

        // start during ACCUM must be ignored
        do_start(2, 0);
        send_beat(pk(1, 1));
        in_valid = 1'b0;
        start    = 1'b1;
        acc_len  = 10'd0;
        num_grp  = 8'd5;
        tick();
        start = 1'b0;
        send_beat(pk(2, 1));
        chk("s5_len_kept", 64'(out_valid), 64'd0);
        send_beat(pk(4, 1));
        in_valid = 1'b0;
        chk("s5_valid", 64'(out_valid), 64'd1);
        chk_lanes("s5_sum", 7, 3);
        chk("s5_grp_kept", 64'(in_ready), 64'd0);
        wait_done();

        // reset mid-command with a pending result
        out_ready = 1'b0;
        do_start(0, 3);
        send_beat(pk(3, 0));
        in_valid = 1'b0;
        chk("s6_pending", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", 64'(out_valid), 64'd0);
        chk("s6_rst_busy", 64'(busy), 64'd0);
        chk("s6_rst_sum_zero", 64'(out_sum == '0), 64'd1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("s6_no_done", 64'(seen_done), 64'd0);
        do_start(0, 0);
        send_beat(pk(9, 1));
        in_valid = 1'b0;
        chk("s6_valid", 64'(out_valid), 64'd1);
        chk_lanes("s6_sum", 9, 1);
        wait_done();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_psum_acc.md
CIM_PSUM_ACC -- requirements
Module: cim_psum_acc

Interface
REQ-001 Parameter LANES, default 8: number of partial-sum lanes, one per CIM column output.
REQ-002 Parameter IN_W, default 8: width of each input partial sum, unsigned.
REQ-003 Parameter ACC_W, default 18: width of each accumulator lane (IN_W+10).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle command pulse; honoured only in IDLE.
REQ-007 acc_len  in  10  beats per group minus one; sampled on start.
REQ-008 num_grp  in  8  groups per command minus one; sampled on start.
REQ-009 in_valid  in  1  partial-sum beat valid.
REQ-010 in_ready  out  1  beat accepted when in_valid and in_ready are both high.
REQ-011 in_psum  in  LANES*IN_W  lane k at bits [k*IN_W +: IN_W].
REQ-012 out_valid  out  1  group result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_sum  out  LANES*ACC_W  lane k at bits [k*ACC_W +: ACC_W].
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse after the final result is handshaken.

Function
REQ-017 The FSM has three states: IDLE, ACCUM and DRAIN.
REQ-018 IDLE -> ACCUM on start: latch acc_len and num_grp, clear the accumulators, beat counter and group counter.
REQ-019 In ACCUM, each accepted beat adds each lane, zero-extended, into its accumulator: acc[k] <= acc[k] + in_psum[k].
REQ-020 The last beat of a group is the accepted beat with beat counter == acc_len; a group is acc_len+1 beats (1..1024).
REQ-021 On the last beat, acc[k] + in_psum[k] is written to out_sum and out_valid is set in the same edge (latency 1 cycle from the last beat).
REQ-022 On the same edge, the accumulators and beat counter clear to 0 and the group counter increments.
REQ-023 The next group's first beat is accepted in the following cycle (no bubble).
REQ-024 in_ready = (state==ACCUM) and not (beat counter==acc_len and out_valid and not out_ready).
REQ-025 The last beat therefore stalls only while the previous result is still pending.
REQ-026 out_valid clears on out_valid and out_ready unless a new result loads in the same edge; in that case it stays 1 with the new data.
REQ-027 out_sum holds stable while out_valid is high and out_ready is low.
REQ-028 After the last beat of group num_grp the FSM moves to DRAIN; in_ready is 0.
REQ-029 DRAIN -> IDLE on the out_valid and out_ready handshake; done pulses high for the cycle after that edge.
REQ-030 start outside IDLE is ignored; in_valid outside ACCUM is ignored.
REQ-031 No overflow is possible with the default widths (1024*255 < 2^18); with user widths the accumulator wraps modulo 2^ACC_W, with no saturation.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE; all counters, accumulators and out_sum = 0; out_valid=0, busy=0, done=0.
REQ-033 Reset asserted mid-command abandons the command and any pending result without a done pulse.

Structure
REQ-034 The defaults LANES/IN_W/ACC_W and the state encoding (IDLE=0, ACCUM=1, DRAIN=2) belong in the shared constant include.
REQ-035 One sub-module, cim_acc_lane (one accumulator lane: clear, add, load-out), is instantiated LANES times.

Verification
REQ-036 Scenario: acc_len=3, num_grp=0, lanes all 0xFF for 4 beats, out_ready=1 -> out_sum each lane 1020, out_valid one cycle after beat 4, then done pulse, back to IDLE.
REQ-037 Scenario: acc_len=1023, lane k = k+1, 1024 beats -> lane k = 1024*(k+1); lane 7 = 8192, no wrap.
REQ-038 Scenario: acc_len=1, num_grp=2, out_ready=0 -> group0 result held, in_ready drops on group1 last beat; raising out_ready releases the stall with no lost or duplicated beats.
REQ-039 Scenario: continuous in_valid, out_ready=1, acc_len=0, num_grp=3 -> four results on consecutive cycles equal to the inputs, no bubbles.
REQ-040 Scenario: rst_n pulsed low mid-group -> outputs zero immediately, no done pulse; a new start then runs cleanly.
REQ-041 Scenario: start asserted during ACCUM -> ignored; acc_len and num_grp unchanged.
